zx_spi_kbd: RTL

Serial keyboard/joystick receiver that sits directly upstream of the port #FE read path and the port #1F (RD_1F) joystick read in the Pentagon top level. It captures 48-bit frames from the keyboard controller MCU on the KBD_CLK / KBD_DI / KBD_CS pins. Each valid frame is committed atomically into an 8×5 key matrix and an 8-bit joystick register. The matrix is then decoded against CPU address lines A[15:8] to produce the active-low key column bits for D[4:0].

---
 rtl/zx_kbd_pkg.sv | 25 ++
 rtl/kbd_sync.sv | 32 +++
 rtl/zx_spi_kbd.sv | 105 ++++++++++
 3 files changed

// File: rtl/zx_kbd_pkg.sv
// Shared constants and types for the serial keyboard/joystick receiver.
// Holds the frame geometry, shift-register slice offsets and FSM state encoding.
package zx_kbd_pkg;

  localparam int FRAME_BITS  = 48;
  localparam int ROWS        = 8;
  localparam int COLS        = 5;
  localparam int JOY_BITS    = 8;
  localparam int MATRIX_BITS = ROWS * COLS;

  // Joystick byte arrives first, so it ends up at the top of the shift register.
  localparam int JOY_LSB = MATRIX_BITS;
  localparam int JOY_MSB = JOY_LSB + JOY_BITS - 1;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/kbd_sync.sv
// N-flop synchronizer plus one history flop; latency STAGES cycles to q, rise/fall
// are combinational from q and the history flop. No backpressure.
module kbd_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Reset to 0 so a pin already low after reset never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/zx_spi_kbd.sv
// SPI keyboard/joystick frame receiver with atomic commit and port #FE column decode.
// Commit lands SYNC_STAGES+2 edges after CS rises; KB is combinational; no backpressure.
module zx_spi_kbd
  import zx_kbd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK_14MHZ,
  input  logic                CPU_RESET,
  input  logic                KBD_CLK,
  input  logic                KBD_DI,
  input  logic                KBD_CS,
  input  logic [ROWS-1:0]     A_HI,
  output logic [COLS-1:0]     KB,
  output logic [JOY_BITS-1:0] JOY,
  output logic                FRAME_OK,
  output logic                FRAME_ERR
);

  logic cs_q, cs_rise, cs_fall;
  logic sck_q, sck_rise, sck_fall;
  logic di_q, di_rise, di_fall;
  logic unused_edges;

  kbd_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(CLK_14MHZ), .rst_n(CPU_RESET), .d(KBD_CS),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  kbd_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(CLK_14MHZ), .rst_n(CPU_RESET), .d(KBD_CLK),
    .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  kbd_sync #(.STAGES(SYNC_STAGES)) u_sync_di (
    .clk(CLK_14MHZ), .rst_n(CPU_RESET), .d(KBD_DI),
    .q(di_q), .rise(di_rise), .fall(di_fall)
  );

  assign unused_edges = ^{sck_q, sck_fall, di_rise, di_fall};

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  sr;
  logic [MATRIX_BITS-1:0] matrix;

  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      matrix    <= '1;
      JOY       <= '0;
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= RECV;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          // A clock edge coincident with the CS rise belongs to no frame.
          if (cs_rise) begin
            state <= CHECK;
          end else if (sck_rise) begin
            sr <= {sr[FRAME_BITS-2:0], di_q};
            if (bit_cnt != CNT_OVF) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (bit_cnt == CNT_FULL) begin
            matrix   <= sr[MATRIX_BITS-1:0];
            JOY      <= sr[JOY_MSB:JOY_LSB];
            FRAME_OK <= 1'b1;
          end else begin
            FRAME_ERR <= 1'b1;
          end
          if (!cs_q) begin
            state   <= RECV;
            bit_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only rows selected by a low address bit can pull a column low.
  always_comb begin
    KB = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        KB[c] = KB[c] & (matrix[r*COLS+c] | A_HI[r]);
      end
    end
  end

endmodule
